einstein_mem_arb: RTL and testbench
===================================

# einstein_mem_arb

Single-port SDRAM request arbiter and sequencer for the Einstein core. It sits between the data_io ROM download stream and the tatung CPU memory strobes (upstream) and the byte-wide `sdram` controller (downstream). It converts level-style CPU strobes and one-cycle `ioctl_wr` pulses into single-cycle `sdram_rd`/`sdram_we` commands, applies the fixed address map, and returns latched read data with a wait handshake.

## Interface
Parameters:
- `DL_DEPTH`, default 2: ioctl write FIFO depth (entries); must be a power of two, at least 2.

Ports:
- `clk_sys` in 1: system clock, 32 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_download` in 1: download in progress; blocks CPU service.
- `ioctl_wr` in 1: one-cycle write pulse.
- `ioctl_addr` in 15: ROM image byte address.
- `ioctl_dout` in 8: write data.
- `cpu_addr` in 16: CPU address.
- `cpu_din` in 8: CPU write data.
- `ram_rd` / `ram_wr` / `roma_rd` / `romb_rd` in 1 each: level requests, at most one high at a time.
- `cpu_dout` out 8: latched read data.
- `cpu_wait` out 1: high while a CPU access is pending.
- `sdram_addr` out 23: command address.
- `sdram_din` out 8: write data.
- `sdram_rd` / `sdram_we` out 1 each: one-cycle command strobes.
- `sdram_dout` in 8: read data.
- `sdram_ready` in 1: controller idle/done.
- `dl_overflow` out 1: sticky flag, set when an ioctl write is dropped.

## Operation
- Address map:
  - ioctl: `{8'd0, ioctl_addr}`.
  - RAM: `{7'd1, cpu_addr}`.
  - ROMA: `{9'd0, cpu_addr[13:0]}`.
  - ROMB: `{8'd0, 1'b1, cpu_addr[13:0]}`.
- Request detection:
  - CPU request = rising edge of (`ram_rd|ram_wr|roma_rd|romb_rd`), captured with addr, data and type in a one-cycle register.
  - A strobe held high does not re-issue. It must fall before the next access is recognised.
- ioctl writes are pushed into the FIFO on `ioctl_wr`. A push while full is dropped and sets `dl_overflow`, which is cleared only by reset.
- FSM states IDLE, ISSUE, WAIT, DONE:
  - IDLE: if FIFO non-empty go to ISSUE (ioctl source); else if CPU pending and `!ioctl_download` go to ISSUE (cpu source). ioctl has strict priority.
  - ISSUE: waits for `sdram_ready`=1, then asserts exactly one of `sdram_rd`/`sdram_we` for one cycle with addr/din valid. Goes to WAIT.
  - WAIT: waits for `sdram_ready` low then high again (busy-then-done). Read data is captured into `cpu_dout` on the done cycle. Goes to DONE.
  - DONE: one cycle. Pops the FIFO or clears the CPU pending flag, drops `cpu_wait`, then returns to IDLE.
- ROM writes from the CPU do not exist. A `roma`/`romb` request is always a read.
- CPU requests arriving during `ioctl_download` stay pending, with `cpu_wait` high, until the download ends and the FIFO is empty.

## Timing
- Reset values:
  - `sdram_rd`=`sdram_we`=0, `sdram_addr`=0, `sdram_din`=0.
  - `cpu_dout`=8'hFF, `cpu_wait`=0, `dl_overflow`=0.
  - FIFO empty, state IDLE.
- `cpu_wait` rises the cycle after the strobe edge is captured. It falls in DONE.
- Minimum CPU latency with `sdram_ready` already high: edge to command is 2 cycles; command to data is controller latency plus 1 cycle.
- Simultaneous `ioctl_wr` push and DONE pop on a full FIFO is accepted: no drop, and the count stays the same.
- Reset mid-operation aborts with no strobe emitted after `reset_n` falls. A half-issued SDRAM command is not retried.
- `cpu_dout` holds its value between reads. Writes do not alter it.

## Structure
- Package `einstein_mem_pkg`:
  - Region base constants: `RAM_BASE`=23'h10000, `ROMA_BASE`=0, `ROMB_BASE`=23'h4000.
  - `typedef enum {IDLE, ISSUE, WAIT, DONE} arb_state_t`.
  - `typedef enum {SRC_IOCTL, SRC_CPU} src_t`.
- Sub-module `einstein_dl_fifo`: parameterised synchronous FIFO with push/pop/full/empty flags and the same async active-low reset.

## Test plan
- Reset, then `ram_rd` at 16'h1234 with the model returning 8'h5A → one `sdram_rd` at 23'h11234, `cpu_dout`=8'h5A, `cpu_wait` cleared, only one command issued while the strobe is held high.
- `romb_rd` at 16'hC010 → `sdram_addr`=23'h04010. `roma_rd` at 16'h0010 → `sdram_addr`=23'h00010.
- `ioctl_download`=1 with 3 back-to-back `ioctl_wr` pulses at addr 0..2, data A0..A2, and `DL_DEPTH`=4 → three `sdram_we` in order with matching addr/data, `dl_overflow`=0.
- Same burst with `DL_DEPTH`=2 and the model holding `sdram_ready` low → third write dropped, `dl_overflow`=1.
- `ram_wr` 16'hFFFF data 8'h77 while the FIFO holds one entry → ioctl write issued first, then `sdram_we` at 23'h1FFFF with din 8'h77. `cpu_dout` stays unchanged.
- Assert `reset_n` low while in WAIT → all outputs return to their reset values asynchronously. After release, no strobe occurs until a new request arrives.

Source files
------------

// File: rtl/einstein_mem_pkg.sv
// rtl/einstein_mem_pkg.sv - shared types, region bases and address map for the Einstein SDRAM arbiter
package einstein_mem_pkg;

    localparam logic [22:0] RAM_BASE  = 23'h10000;
    localparam logic [22:0] ROMA_BASE = 23'h00000;
    localparam logic [22:0] ROMB_BASE = 23'h04000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
    typedef enum logic {SRC_IOCTL, SRC_CPU} src_t;

    // ROM regions only decode the low 16 KiB of the CPU address
    function automatic logic [22:0] cpu_map(input logic ram, input logic romb, input logic [15:0] a);
        if (ram)
            return RAM_BASE | {7'd0, a};
        else if (romb)
            return ROMB_BASE | {9'd0, a[13:0]};
        else
            return ROMA_BASE | {9'd0, a[13:0]};
    endfunction

endpackage

// File: rtl/einstein_dl_fifo.sv
// rtl/einstein_dl_fifo.sv - small synchronous FIFO buffering ROM download writes
module einstein_dl_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 23
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so a push on a full FIFO is still taken
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/einstein_mem_arb.sv
// rtl/einstein_mem_arb.sv - arbitrates ROM download writes and CPU strobes onto the byte-wide SDRAM controller
module einstein_mem_arb
    import einstein_mem_pkg::*;
#(
    parameter int DL_DEPTH = 2
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [14:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        ram_rd,
    input  logic        ram_wr,
    input  logic        roma_rd,
    input  logic        romb_rd,
    output logic [7:0]  cpu_dout,
    output logic        cpu_wait,
    output logic [22:0] sdram_addr,
    output logic [7:0]  sdram_din,
    output logic        sdram_rd,
    output logic        sdram_we,
    input  logic [7:0]  sdram_dout,
    input  logic        sdram_ready,
    output logic        dl_overflow
);

    arb_state_t  state;
    src_t        src;
    logic        seen_busy;
    logic        req_q;
    logic        cpu_pend;
    logic        cpu_we_q;
    logic [22:0] cpu_addr_q;
    logic [7:0]  cpu_din_q;

    logic        cpu_req;
    logic        cpu_edge;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [22:0] fifo_dout;

    assign cpu_req  = ram_rd | ram_wr | roma_rd | romb_rd;
    assign cpu_edge = cpu_req && !req_q;
    assign fifo_pop = (state == DONE) && (src == SRC_IOCTL);

    einstein_dl_fifo #(
        .DEPTH (DL_DEPTH),
        .WIDTH (23)
    ) u_dl_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .push    (ioctl_wr),
        .pop     (fifo_pop),
        .din     ({ioctl_addr, ioctl_dout}),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            src         <= SRC_IOCTL;
            seen_busy   <= 1'b0;
            req_q       <= 1'b0;
            cpu_pend    <= 1'b0;
            cpu_we_q    <= 1'b0;
            cpu_addr_q  <= '0;
            cpu_din_q   <= '0;
            cpu_dout    <= 8'hFF;
            cpu_wait    <= 1'b0;
            sdram_addr  <= '0;
            sdram_din   <= '0;
            sdram_rd    <= 1'b0;
            sdram_we    <= 1'b0;
            dl_overflow <= 1'b0;
        end else begin
            req_q    <= cpu_req;
            sdram_rd <= 1'b0;
            sdram_we <= 1'b0;
            if (ioctl_wr && fifo_full && !fifo_pop)
                dl_overflow <= 1'b1;
            if (cpu_pend)
                cpu_wait <= 1'b1;

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        src   <= SRC_IOCTL;
                        state <= ISSUE;
                    end else if (cpu_pend && !ioctl_download) begin
                        src   <= SRC_CPU;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sdram_ready) begin
                        seen_busy <= 1'b0;
                        state     <= WAIT;
                        if (src == SRC_IOCTL) begin
                            sdram_addr <= {8'd0, fifo_dout[22:8]};
                            sdram_din  <= fifo_dout[7:0];
                            sdram_we   <= 1'b1;
                        end else begin
                            sdram_addr <= cpu_addr_q;
                            sdram_din  <= cpu_din_q;
                            sdram_we   <= cpu_we_q;
                            sdram_rd   <= !cpu_we_q;
                        end
                    end
                end
                WAIT: begin
                    // ready must drop first so the done edge belongs to our command
                    if (!sdram_ready)
                        seen_busy <= 1'b1;
                    else if (seen_busy) begin
                        state <= DONE;
                        if (src == SRC_CPU && !cpu_we_q)
                            cpu_dout <= sdram_dout;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (src == SRC_CPU) begin
                        cpu_pend <= 1'b0;
                        cpu_wait <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (cpu_edge && (!cpu_pend || (state == DONE && src == SRC_CPU))) begin
                cpu_pend   <= 1'b1;
                cpu_we_q   <= ram_wr;
                cpu_addr_q <= cpu_map(ram_rd | ram_wr, romb_rd, cpu_addr);
                cpu_din_q  <= cpu_din;
            end
        end
    end

endmodule

// File: tb/tb_einstein_mem_arb.sv
// tb/tb_einstein_mem_arb.sv - scoreboard bench for einstein_mem_arb with a small SDRAM controller model
module tb_einstein_mem_arb;

    typedef struct packed {
        logic        we;
        logic [22:0] addr;
        logic [7:0]  din;
    } cmd_t;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download, ioctl_wr;
    logic [14:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        ram_rd, ram_wr, roma_rd, romb_rd;
    logic [7:0]  cpu_dout;
    logic        cpu_wait;
    logic [22:0] sdram_addr;
    logic [7:0]  sdram_din;
    logic        sdram_rd, sdram_we;
    logic [7:0]  sdram_dout;
    logic        sdram_ready;
    logic        dl_overflow;

    logic [7:0]  d2_cpu_dout, d2_sdram_din;
    logic        d2_cpu_wait, d2_sdram_rd, d2_sdram_we, d2_dl_overflow;
    logic [22:0] d2_sdram_addr;
    logic        d2_ready = 1'b0;
    logic [7:0]  d2_sdram_dout = 8'h00;

    int   checks = 0;
    int   failures = 0;
    int   n_cmd = 0;
    int   n0;
    cmd_t exp_q[$];

    logic        pend_we;
    logic [22:0] pend_addr;
    int          lat_cnt;

    always #5 clk_sys = ~clk_sys;

    einstein_mem_arb #(.DL_DEPTH(4)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .ram_rd(ram_rd), .ram_wr(ram_wr),
        .roma_rd(roma_rd), .romb_rd(romb_rd), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
        .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_rd(sdram_rd),
        .sdram_we(sdram_we), .sdram_dout(sdram_dout), .sdram_ready(sdram_ready),
        .dl_overflow(dl_overflow)
    );

    einstein_mem_arb #(.DL_DEPTH(2)) dut2 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .ram_rd(ram_rd), .ram_wr(ram_wr),
        .roma_rd(roma_rd), .romb_rd(romb_rd), .cpu_dout(d2_cpu_dout), .cpu_wait(d2_cpu_wait),
        .sdram_addr(d2_sdram_addr), .sdram_din(d2_sdram_din), .sdram_rd(d2_sdram_rd),
        .sdram_we(d2_sdram_we), .sdram_dout(d2_sdram_dout), .sdram_ready(d2_ready),
        .dl_overflow(d2_dl_overflow)
    );

    function automatic logic [7:0] rom_byte(input logic [22:0] a);
        case (a)
            23'h11234: return 8'h5A;
            23'h04010: return 8'h3C;
            23'h00010: return 8'hC3;
            default:   return 8'h00;
        endcase
    endfunction

    // Controller model: ready drops the cycle after a command, returns 3 cycles later
    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sdram_ready <= 1'b1;
            sdram_dout  <= 8'h00;
            lat_cnt     <= 0;
            pend_we     <= 1'b0;
            pend_addr   <= '0;
        end else if (sdram_rd || sdram_we) begin
            sdram_ready <= 1'b0;
            lat_cnt     <= 3;
            pend_we     <= sdram_we;
            pend_addr   <= sdram_addr;
        end else if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) begin
                sdram_ready <= 1'b1;
                if (!pend_we)
                    sdram_dout <= rom_byte(pend_addr);
            end
        end
    end

    always @(negedge clk_sys) begin
        if (reset_n && (sdram_rd || sdram_we)) begin
            cmd_t e;
            n_cmd++;
            checks++;
            if (sdram_rd && sdram_we) begin
                failures++;
                $display("FAIL cmd_both: got rd=1 we=1, required exactly one strobe");
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL cmd_unexpected: got we=%0b addr=%h, required no command", sdram_we, sdram_addr);
            end else begin
                e = exp_q.pop_front();
                if (sdram_we !== e.we || sdram_addr !== e.addr || (e.we && sdram_din !== e.din)) begin
                    failures++;
                    $display("FAIL cmd: got we=%0b addr=%h din=%h, required we=%0b addr=%h din=%h",
                             sdram_we, sdram_addr, sdram_din, e.we, e.addr, e.din);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic wait_cpu_wait(input logic lvl, input int bound, input string name);
        int n = 0;
        while (cpu_wait !== lvl && n < bound) begin
            @(negedge clk_sys);
            n++;
        end
        check(name, cpu_wait, lvl);
    endtask

    task automatic cpu_access(input int kind, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        cpu_addr = a;
        cpu_din  = d;
        ram_rd   = (kind == 0);
        ram_wr   = (kind == 1);
        roma_rd  = (kind == 2);
        romb_rd  = (kind == 3);
        wait_cpu_wait(1'b1, 10, "cpu_wait_rise");
        wait_cpu_wait(1'b0, 200, "cpu_wait_fall");
        repeat (5) @(negedge clk_sys);
        {ram_rd, ram_wr, roma_rd, romb_rd} = 4'b0;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk_sys);
            n++;
        end
        repeat (10) @(negedge clk_sys);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        {ioctl_download, ioctl_wr, ram_rd, ram_wr, roma_rd, romb_rd} = 6'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        cpu_addr   = '0;
        cpu_din    = '0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        check("rst_sdram_rd", sdram_rd, 0);
        check("rst_sdram_we", sdram_we, 0);
        check("rst_sdram_addr", sdram_addr, 0);
        check("rst_sdram_din", sdram_din, 0);
        check("rst_cpu_dout", cpu_dout, 8'hFF);
        check("rst_cpu_wait", cpu_wait, 0);
        check("rst_overflow", dl_overflow, 0);

        // RAM read, strobe held past completion
        n0 = n_cmd;
        exp_q.push_back('{we: 1'b0, addr: 23'h11234, din: 8'h00});
        cpu_access(0, 16'h1234, 8'h00);
        check("ram_rd_data", cpu_dout, 8'h5A);
        check("ram_rd_one_cmd", n_cmd - n0, 1);

        exp_q.push_back('{we: 1'b0, addr: 23'h04010, din: 8'h00});
        cpu_access(3, 16'hC010, 8'h00);
        check("romb_rd_data", cpu_dout, 8'h3C);
        exp_q.push_back('{we: 1'b0, addr: 23'h00010, din: 8'h00});
        cpu_access(2, 16'h0010, 8'h00);
        check("roma_rd_data", cpu_dout, 8'hC3);

        // Three back-to-back download writes
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ioctl_addr = 15'(i);
            ioctl_dout = 8'hA0 + 8'(i);
            ioctl_wr   = 1'b1;
            exp_q.push_back('{we: 1'b1, addr: 23'(i), din: 8'hA0 + 8'(i)});
            @(negedge clk_sys);
        end
        ioctl_wr = 1'b0;
        check("depth2_overflow", d2_dl_overflow, 1);
        drain(200);
        check("depth4_no_overflow", dl_overflow, 0);

        // CPU write queued behind a download entry, held off by ioctl_download
        ioctl_addr = 15'd5;
        ioctl_dout = 8'h55;
        ioctl_wr   = 1'b1;
        cpu_addr   = 16'hFFFF;
        cpu_din    = 8'h77;
        ram_wr     = 1'b1;
        exp_q.push_back('{we: 1'b1, addr: 23'h00005, din: 8'h55});
        exp_q.push_back('{we: 1'b1, addr: 23'h1FFFF, din: 8'h77});
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        repeat (20) @(negedge clk_sys);
        check("cpu_wait_during_dl", cpu_wait, 1);
        check("ioctl_first", exp_q.size(), 1);
        ioctl_download = 1'b0;
        wait_cpu_wait(1'b0, 200, "ram_wr_done");
        ram_wr = 1'b0;
        drain(50);
        check("ram_wr_dout_kept", cpu_dout, 8'hC3);

        // Reset while the controller is busy
        n0 = n_cmd;
        @(negedge clk_sys);
        cpu_addr = 16'h0100;
        ram_rd   = 1'b1;
        exp_q.push_back('{we: 1'b0, addr: 23'h10100, din: 8'h00});
        for (int n = 0; n < 20 && n_cmd == n0; n++)
            @(negedge clk_sys);
        check("abort_cmd_seen", n_cmd - n0, 1);
        @(negedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        check("arst_sdram_rd", sdram_rd, 0);
        check("arst_sdram_we", sdram_we, 0);
        check("arst_sdram_addr", sdram_addr, 0);
        check("arst_sdram_din", sdram_din, 0);
        check("arst_cpu_dout", cpu_dout, 8'hFF);
        check("arst_cpu_wait", cpu_wait, 0);
        check("arst_d2_overflow", d2_dl_overflow, 0);
        ram_rd = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        n0 = n_cmd;
        repeat (20) @(negedge clk_sys);
        check("no_cmd_after_reset", n_cmd - n0, 0);

        exp_q.push_back('{we: 1'b0, addr: 23'h11234, din: 8'h00});
        cpu_access(0, 16'h1234, 8'h00);
        check("post_reset_rd", cpu_dout, 8'h5A);
        drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
